// File: rtl/fmap_stream_if.sv
// Valid/ready stream carrying one feature-map element plus its indices and
// end-of-row/channel/map flags.
interface fmap_stream_if #(
    parameter int DATA_WIDTH = 16,
    parameter int CHANNELS   = 8,
    parameter int IMG_SIZE   = 28
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int IW = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;

    // Handshake: an element transfers in a cycle where m_valid && m_ready;
    // once m_valid rises, payload and flags hold until that transfer.
    logic                         m_valid;
    logic                         m_ready;
    logic signed [DATA_WIDTH-1:0] m_data;
    logic [CW-1:0]                m_chan;
    logic [IW-1:0]                m_row;
    logic [IW-1:0]                m_col;
    logic                         m_last_row;
    logic                         m_last_chan;
    logic                         m_last;

    modport master (
        output m_valid, m_data, m_chan, m_row, m_col, m_last_row, m_last_chan, m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid, m_data, m_chan, m_row, m_col, m_last_row, m_last_chan, m_last,
        output m_ready
    );
endinterface

// File: rtl/fmap_stream_tx.sv
// Streams a whole feature map once per start, channel-major, one element per beat.
// Optional nonzero-beat counter enabled by FMAP_STREAM_NZ_COUNT_EN.
module fmap_stream_tx #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 7,
    parameter int CHANNELS   = 8,
    parameter int IMG_SIZE   = 28,
    localparam int CW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int IW  = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1,
    localparam int N   = CHANNELS * IMG_SIZE * IMG_SIZE,
    localparam int NZW = $clog2(N + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic signed [DATA_WIDTH-1:0] in_feature [0:CHANNELS-1][0:IMG_SIZE-1][0:IMG_SIZE-1],
    fmap_stream_if.master                m,
    output logic                         busy,
    output logic                         done,
    output logic [1:0]                   dbg_state
`ifdef FMAP_STREAM_NZ_COUNT_EN
    ,
    output logic [NZW-1:0]               nz_count
`endif
);
    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, FINISH = 2'd2} state_t;

    // Fixed-point position is meaningful only to producers and consumers.
    if (FRAC_BITS >= DATA_WIDTH) begin : g_frac_check
        $error("FRAC_BITS must be smaller than DATA_WIDTH");
    end

    localparam logic [CW-1:0] LAST_CHAN = CW'(CHANNELS - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(IMG_SIZE - 1);

    state_t                       state_q, state_d;
    logic                         valid_q;
    logic signed [DATA_WIDTH-1:0] data_q;
    logic [CW-1:0]                chan_q, next_chan;
    logic [IW-1:0]                row_q, col_q, next_row, next_col;
    logic                         at_last_col, at_last_row, at_last_elem;
    logic                         beat, load_first, advance, finish;

    assign at_last_col  = (col_q == LAST_IDX);
    assign at_last_row  = at_last_col && (row_q == LAST_IDX);
    assign at_last_elem = at_last_row && (chan_q == LAST_CHAN);
    assign beat         = valid_q && m.m_ready;

    always_comb begin
        next_col  = at_last_col ? '0 : col_q + 1'b1;
        next_row  = row_q;
        next_chan = chan_q;
        if (at_last_col) begin
            next_row = (row_q == LAST_IDX) ? '0 : row_q + 1'b1;
        end
        if (at_last_row) begin
            next_chan = chan_q + 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        load_first = 1'b0;
        advance    = 1'b0;
        finish     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load_first = 1'b1;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (beat) begin
                    if (at_last_elem) begin
                        finish  = 1'b1;
                        state_d = FINISH;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            data_q  <= '0;
            chan_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load_first) begin
                valid_q <= 1'b1;
                data_q  <= in_feature[0][0][0];
                chan_q  <= '0;
                row_q   <= '0;
                col_q   <= '0;
            end else if (advance) begin
                data_q <= in_feature[next_chan][next_row][next_col];
                chan_q <= next_chan;
                row_q  <= next_row;
                col_q  <= next_col;
            end else if (finish) begin
                valid_q <= 1'b0;
            end
        end
    end

`ifdef FMAP_STREAM_NZ_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset || load_first) begin
            nz_count <= '0;
        end else if (beat && (data_q != '0)) begin
            nz_count <= nz_count + 1'b1;
        end
    end
`endif

    // Flags are qualified by valid so idle/reset outputs read as zero for any geometry.
    assign m.m_valid     = valid_q;
    assign m.m_data      = data_q;
    assign m.m_chan      = chan_q;
    assign m.m_row       = row_q;
    assign m.m_col       = col_q;
    assign m.m_last_row  = valid_q && at_last_col;
    assign m.m_last_chan = valid_q && at_last_row;
    assign m.m_last      = valid_q && at_last_elem;

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FINISH);
    assign dbg_state = state_q;
endmodule

// File: tb/tb_fmap_stream_tx.sv
// Directed bench: 2x3x3 map (value 9c+3r+q-4) plus a 1x1x1 map holding 0x7FFF.
module tb_fmap_stream_tx;
    logic clk = 1'b0;
    logic reset;
    logic start, start1;
    logic busy, done, busy1, done1;
    logic [1:0] st, st1;
    logic signed [15:0] fmap [0:1][0:2][0:2];
    logic signed [15:0] fm1  [0:0][0:0][0:0];
`ifdef FMAP_STREAM_NZ_COUNT_EN
    logic [4:0] nz;
    logic [0:0] nz1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fmap_stream_if #(.DATA_WIDTH(16), .CHANNELS(2), .IMG_SIZE(3)) s ();
    fmap_stream_if #(.DATA_WIDTH(16), .CHANNELS(1), .IMG_SIZE(1)) s1 ();

    fmap_stream_tx #(.DATA_WIDTH(16), .FRAC_BITS(7), .CHANNELS(2), .IMG_SIZE(3)) dut (
        .clk(clk), .reset(reset), .start(start), .in_feature(fmap), .m(s.master),
        .busy(busy), .done(done), .dbg_state(st)
`ifdef FMAP_STREAM_NZ_COUNT_EN
        , .nz_count(nz)
`endif
    );

    fmap_stream_tx #(.DATA_WIDTH(16), .FRAC_BITS(7), .CHANNELS(1), .IMG_SIZE(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .in_feature(fm1), .m(s1.master),
        .busy(busy1), .done(done1), .dbg_state(st1)
`ifdef FMAP_STREAM_NZ_COUNT_EN
        , .nz_count(nz1)
`endif
    );

    typedef struct {
        bit start;
        bit ready;
        bit e_valid;
        int e_data;
        int e_chan;
        int e_row;
        int e_col;
        bit e_lr;
        bit e_lc;
        bit e_l;
        bit e_done;
        bit e_busy;
    } vec_t;

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d @%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_map(input bit neg);
        for (int c = 0; c < 2; c++)
            for (int r = 0; r < 3; r++)
                for (int q = 0; q < 3; q++)
                    fmap[c][r][q] = neg ? 16'(-(9*c + 3*r + q - 4)) : 16'(9*c + 3*r + q - 4);
    endtask

    // mode 0: ready always 1; mode 1: ready 1,0,0,1 repeating; mode 2: ready 1 with stray starts
    task automatic run_seq(input int mode, input bit neg, input string tag);
        logic [15:0] exp_q[$];
        int beats = 0;
        int dones = 0;
        int cyc = 0;
        int last_beat_cyc = -10;
        bit fin = 0;
        bit rdy;
        for (int k = 0; k < 18; k++) exp_q.push_back(neg ? 16'(-(k - 4)) : 16'(k - 4));
        start = 1'b1;
        step();
        start = 1'b0;
        while (!fin && cyc < 200) begin
            rdy = (mode == 1) ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
            s.m_ready = rdy;
            start = 1'b0;
            if (mode == 2 && s.m_valid && (beats == 4 || beats == 11)) start = 1'b1;
            if (done) begin
                dones++;
                fin = 1'b1;
                chk({tag, "_done_timing"}, cyc, last_beat_cyc + 1);
`ifdef FMAP_STREAM_NZ_COUNT_EN
                chk({tag, "_nz_count"}, nz, 17);
`endif
                if (mode == 2) start = 1'b1;
            end else begin
                chk({tag, "_busy"}, busy, 1);
            end
            if (s.m_valid) begin
                if (exp_q.size() == 0) begin
                    chk({tag, "_extra_beat"}, 1, 0);
                end else begin
                    chk({tag, "_data"}, $signed(s.m_data), $signed(exp_q[0]));
                    chk({tag, "_chan"}, s.m_chan, beats / 9);
                    chk({tag, "_row"}, s.m_row, (beats / 3) % 3);
                    chk({tag, "_col"}, s.m_col, beats % 3);
                    chk({tag, "_last_row"}, s.m_last_row, (beats % 3) == 2);
                    chk({tag, "_last_chan"}, s.m_last_chan, (beats % 9) == 8);
                    chk({tag, "_last"}, s.m_last, beats == 17);
                    if (rdy) begin
                        void'(exp_q.pop_front());
                        beats++;
                        last_beat_cyc = cyc;
                    end
                end
            end
            step();
            cyc++;
        end
        start = 1'b0;
        chk({tag, "_finished"}, fin, 1);
        chk({tag, "_beats"}, beats, 18);
        chk({tag, "_dones"}, dones, 1);
        chk({tag, "_queue_left"}, exp_q.size(), 0);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_quiet_valid"}, s.m_valid, 0);
            chk({tag, "_quiet_done"}, done, 0);
            step();
        end
    endtask

    initial begin
        vec_t tbl [21];
        tbl[0] = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        for (int k = 0; k < 18; k++)
            tbl[k+1] = '{0, 1, 1, k - 4, k / 9, (k / 3) % 3, k % 3,
                         (k % 3) == 2, (k % 9) == 8, k == 17, 0, 1};
        tbl[19] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
        tbl[20] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

        set_map(0);
        fm1[0][0][0] = 16'sh7FFF;
        reset = 1'b1;
        start = 1'b0;
        start1 = 1'b0;
        s.m_ready = 1'b1;
        s1.m_ready = 1'b1;
        repeat (3) step();

        chk("rst_valid", s.m_valid, 0);
        chk("rst_data", s.m_data, 0);
        chk("rst_idx", {s.m_chan, s.m_row, s.m_col}, 0);
        chk("rst_flags", {s.m_last_row, s.m_last_chan, s.m_last}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_state", st, 0);
        chk("rst1_valid", s1.m_valid, 0);
        chk("rst1_flags", {s1.m_last_row, s1.m_last_chan, s1.m_last}, 0);
        chk("rst1_busy_done", {busy1, done1}, 0);
`ifdef FMAP_STREAM_NZ_COUNT_EN
        chk("rst_nz", nz, 0);
`endif
        reset = 1'b0;
        step();

        for (int i = 0; i < 21; i++) begin
            start = tbl[i].start;
            s.m_ready = tbl[i].ready;
            chk("tbl_valid", s.m_valid, tbl[i].e_valid);
            chk("tbl_done", done, tbl[i].e_done);
            chk("tbl_busy", busy, tbl[i].e_busy);
            if (tbl[i].e_valid) begin
                chk("tbl_data", $signed(s.m_data), tbl[i].e_data);
                chk("tbl_chan", s.m_chan, tbl[i].e_chan);
                chk("tbl_row", s.m_row, tbl[i].e_row);
                chk("tbl_col", s.m_col, tbl[i].e_col);
                chk("tbl_last_row", s.m_last_row, tbl[i].e_lr);
                chk("tbl_last_chan", s.m_last_chan, tbl[i].e_lc);
                chk("tbl_last", s.m_last, tbl[i].e_l);
            end
`ifdef FMAP_STREAM_NZ_COUNT_EN
            if (tbl[i].e_done) chk("tbl_nz_count", nz, 17);
`endif
            step();
        end
        start = 1'b0;

        run_seq(1, 0, "bp");
        run_seq(2, 0, "stray_start");

        // abort after beat 7 while stalled
        s.m_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (7) step();
        chk("abort_pre_data", $signed(s.m_data), 3);
        s.m_ready = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_valid", s.m_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        for (int i = 0; i < 3; i++) begin
            chk("abort_quiet", {s.m_valid, done}, 0);
            step();
        end
        run_seq(0, 0, "after_abort");

        set_map(1);
        run_seq(0, 1, "neg");
        set_map(0);

        start1 = 1'b1;
        s1.m_ready = 1'b1;
        step();
        start1 = 1'b0;
        chk("one_valid", s1.m_valid, 1);
        chk("one_data", $signed(s1.m_data), 32767);
        chk("one_idx", {s1.m_chan, s1.m_row, s1.m_col}, 0);
        chk("one_flags", {s1.m_last_row, s1.m_last_chan, s1.m_last}, 7);
        chk("one_done_early", done1, 0);
        step();
        chk("one_done", done1, 1);
        chk("one_busy", busy1, 1);
        chk("one_valid_after", s1.m_valid, 0);
`ifdef FMAP_STREAM_NZ_COUNT_EN
        chk("one_nz", nz1, 1);
`endif
        step();
        chk("one_idle", {done1, busy1}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fmap_stream_tx.md
Name: fmap_stream_tx

Overview:
- Reader/transmitter for the feature-map arrays that the activation layers write (e.g. the ReLU output array).
- On `start`, walks the whole map once in channel-major order (c, then r, then q fastest) and emits one element per beat on a valid/ready stream.
- Feeds serial consumers downstream: pooling front-end, result UART, debug capture.
- Pulses `done` once the final element has been accepted.

Parameters:
- DATA_WIDTH, 16, signed element width.
- FRAC_BITS, 7, fractional bits; carried for consistency, no effect on logic.
- CHANNELS, 8, number of channels.
- IMG_SIZE, 28, feature-map height = width.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin one full-map transfer; honoured only in IDLE.
- in_feature  input  signed [DATA_WIDTH-1:0] [0:CHANNELS-1][0:IMG_SIZE-1][0:IMG_SIZE-1]  source map; must stay stable while busy.
- m_valid  output  1  element on m_data is valid.
- m_ready  input  1  consumer accepts the current element.
- m_data  output  signed [DATA_WIDTH-1:0]  current element, registered.
- m_chan  output  $clog2(CHANNELS) (min 1)  channel index of m_data.
- m_row  output  $clog2(IMG_SIZE) (min 1)  row index of m_data.
- m_col  output  $clog2(IMG_SIZE) (min 1)  column index of m_data.
- m_last_row  output  1  element is the final column of a row.
- m_last_chan  output  1  element is the final element of a channel.
- m_last  output  1  element is the final element of the map.
- busy  output  1  high in SEND and FINISH.
- done  output  1  one-cycle pulse at end of transfer.

Behaviour:
- Reset: every output is 0 (m_data, indices, flags, m_valid, busy, done); state = IDLE. Reset wins over all other inputs. Reset mid-transfer aborts the transfer: m_valid is 0 from the next cycle and no done pulse is produced.
- Definitions: N = CHANNELS*IMG_SIZE*IMG_SIZE. A beat occurs in a cycle where m_valid && m_ready.
- State IDLE:
  - done = 0.
  - When start is sampled, load element [0][0][0] with its indices and flags into the output registers, set m_valid = 1, go to SEND.
  - The first element is therefore visible the cycle after start.
- State SEND:
  - On a beat that is not the last element: load the next element (q+1; on q wrap, r+1; on r wrap, c+1) into the output registers the same edge. m_valid stays 1, so throughput is 1 beat/cycle.
  - No beat (m_ready = 0): m_data, indices and flags hold exactly. m_valid never drops mid-transfer.
  - Beat on the element with m_last = 1: clear m_valid, go to FINISH.
- State FINISH: done = 1 for exactly one cycle, busy = 1, then go to IDLE.
- Timing with m_ready held at 1: m_valid is high for N consecutive cycles, and done is high in the cycle immediately after the final beat.
- Flags, combinatorially tied to the registered indices:
  - m_last_row = (col == IMG_SIZE-1).
  - m_last_chan = m_last_row && (row == IMG_SIZE-1).
  - m_last = m_last_chan && (chan == CHANNELS-1).
- start while busy is ignored; it is neither queued nor allowed to restart the transfer.
- start sampled in the same cycle done is high (state FINISH) is ignored. start is accepted the following cycle (IDLE).
- m_ready high while m_valid = 0 has no effect.
- Data passes through unmodified, with no sign or saturation processing.
- CHANNELS = 1 and IMG_SIZE = 1 are legal. With both at 1, N = 1 and the single element carries every last flag.

Optional Feature:
- Macro: FMAP_STREAM_NZ_COUNT_EN.
- Defined:
  - Adds output nz_count, width $clog2(N+1).
  - Counts beats where m_data != 0.
  - Cleared when start is accepted; final value is valid while done = 1 and held until the next accepted start.
  - Reset value 0.
- Undefined: the port and the counter do not exist; all other behaviour is identical.

Test Plan (CHANNELS=2, IMG_SIZE=3, N=18, in_feature[c][r][q] = 9c+3r+q-4):
- Reset, then start with m_ready held at 1:
  - 18 beats carrying -4..13 in order, one per cycle.
  - m_last_row on beats 3, 6, 9, 12, 15, 18; m_last_chan on beats 9 and 18; m_last on beat 18 only.
  - done high only in the cycle after beat 18.
- Backpressure, m_ready toggled 1,0,0,1 repeating: m_data/indices stable on every stall cycle, still 18 beats in order -4..13, no duplicates or drops, single done.
- start pulsed at beats 5 and 12 and in the done cycle: sequence unaltered, exactly one done, and no new transfer begins until a start in IDLE.
- Reset asserted after beat 7 with m_ready = 0: next cycle m_valid = 0, busy = 0, no done. A new start then streams from [0][0][0] with value -4.
- FMAP_STREAM_NZ_COUNT_EN defined, same map: nz_count = 17 while done is high (value 0 at c0,r1,q1 is excluded). Negate all values, rerun: nz_count = 17.
- CHANNELS=1, IMG_SIZE=1, element = 16'sh7FFF: one beat carrying 0x7FFF with m_last = m_last_chan = m_last_row = 1, done the next cycle.
